// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, control-bit positions
// and default datapath widths.
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Bit positions inside the 2-bit wb/mem control bundles
  localparam int unsigned REG_WRITE  = 1;
  localparam int unsigned MEM_TO_REG = 0;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_WRITE  = 0;

  localparam int unsigned WORD_SIZE_DEF = 32;
  localparam int unsigned REG_SIZE_DEF  = 5;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads every cycle, bubble forces an all-zero
// (RegWrite=0) entry.
module mem_wb_reg
  import riscv_pkg::*;
#(
  parameter int unsigned word_size = WORD_SIZE_DEF,
  parameter int unsigned reg_size  = REG_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bubble,
  input  logic [1:0]           wb_ctrl_in,
  input  logic [word_size-1:0] read_data_in,
  input  logic [word_size-1:0] alu_result_in,
  input  logic [reg_size-1:0]  dest_reg_in,
  output logic [1:0]           wb_ctrl_q,
  output logic [word_size-1:0] read_data_q,
  output logic [word_size-1:0] alu_result_q,
  output logic [reg_size-1:0]  dest_reg_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctrl_q    <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      dest_reg_q   <= '0;
    end else if (bubble) begin
      wb_ctrl_q    <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      dest_reg_q   <= '0;
    end else begin
      wb_ctrl_q    <= wb_ctrl_in;
      read_data_q  <= read_data_in;
      alu_result_q <= alu_result_in;
      dest_reg_q   <= dest_reg_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage with handshaked variable-latency data port.
// Optional busy watchdog enabled by defining DMEM_TIMEOUT_EN.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned word_size      = WORD_SIZE_DEF,
  parameter int unsigned reg_size       = REG_SIZE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [1:0]           ex_wb_ctrl,
  input  logic [1:0]           ex_mem_ctrl,
  input  logic [word_size-1:0] ex_alu_result,
  input  logic [word_size-1:0] ex_store_data,
  input  logic [reg_size-1:0]  ex_dest_reg,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [word_size-1:0] dmem_addr,
  output logic [word_size-1:0] dmem_wdata,
  input  logic [word_size-1:0] dmem_rdata,
  input  logic                 dmem_ack,
  output logic [1:0]           wb_control_signals,
  output logic [word_size-1:0] ReadData,
  output logic [word_size-1:0] AluResult,
  output logic [reg_size-1:0]  destination_reg,
  output logic                 mem_fault
);

  mem_state_t state, state_next;

  logic                 memop, misaligned, is_store;
  logic                 capture, timeout, fault_d;
  logic                 wb_bubble;
  logic [1:0]           wb_ctrl_d;
  logic [word_size-1:0] rdata_d, alu_d;
  logic [reg_size-1:0]  dest_d;

  // Holding registers; the captured address doubles as the ALU result
  logic [word_size-1:0] h_addr, h_wdata;
  logic                 h_we;
  logic [1:0]           h_wb;
  logic [reg_size-1:0]  h_dest;

  assign memop      = ex_mem_ctrl[MEM_READ] | ex_mem_ctrl[MEM_WRITE];
  assign misaligned = (ex_alu_result[1:0] != 2'b00);
  assign is_store   = ex_mem_ctrl[MEM_WRITE] & ~ex_mem_ctrl[MEM_READ];

  assign dmem_req   = (state == BUSY);
  assign dmem_we    = dmem_req & h_we;
  assign dmem_addr  = h_addr;
  assign dmem_wdata = h_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mem_stall  = 1'b0;
    fault_d    = 1'b0;
    wb_bubble  = 1'b1;
    wb_ctrl_d  = '0;
    rdata_d    = '0;
    alu_d      = '0;
    dest_d     = '0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!memop) begin
            wb_bubble = 1'b0;
            wb_ctrl_d = ex_wb_ctrl;
            alu_d     = ex_alu_result;
            dest_d    = ex_dest_reg;
          end else if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            mem_stall  = 1'b1;
            capture    = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // Ack takes priority over a coincident watchdog expiry
        if (dmem_ack) begin
          state_next            = IDLE;
          wb_bubble             = 1'b0;
          wb_ctrl_d[REG_WRITE]  = h_wb[REG_WRITE];
          wb_ctrl_d[MEM_TO_REG] = h_wb[MEM_TO_REG];
          rdata_d               = h_we ? '0 : dmem_rdata;
          alu_d                 = h_addr;
          dest_d                = h_dest;
        end else if (timeout) begin
          state_next = IDLE;
          fault_d    = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_addr  <= '0;
      h_wdata <= '0;
      h_we    <= 1'b0;
      h_wb    <= '0;
      h_dest  <= '0;
    end else if (capture) begin
      h_addr  <= ex_alu_result;
      h_wdata <= ex_store_data;
      h_we    <= is_store;
      h_wb    <= ex_wb_ctrl;
      h_dest  <= ex_dest_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= fault_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;

  // busy_cnt holds (BUSY cycles elapsed - 1); expiry on the last allowed cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (capture) begin
      busy_cnt <= '0;
    end else if (state == BUSY) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && (busy_cnt == CNT_LAST);
`else
  // Watchdog absent: constant-false, still referencing the limit parameter
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  mem_wb_reg #(
    .word_size (word_size),
    .reg_size  (reg_size)
  ) u_mem_wb_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .bubble        (wb_bubble),
    .wb_ctrl_in    (wb_ctrl_d),
    .read_data_in  (rdata_d),
    .alu_result_in (alu_d),
    .dest_reg_in   (dest_d),
    .wb_ctrl_q     (wb_control_signals),
    .read_data_q   (ReadData),
    .alu_result_q  (AluResult),
    .dest_reg_q    (destination_reg)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; watchdog scenarios run when
// DMEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_wb_ctrl, ex_mem_ctrl;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  wb_control_signals;
  logic [31:0] ReadData, AluResult;
  logic [4:0]  destination_reg;
  logic        mem_fault;

  int total = 0;
  int bad = 0;
  int req_rises = 0;
  int rises_before;

  always #5 clk = ~clk;
  always @(posedge dmem_req) req_rises++;

  mem_stage #(
    .word_size      (32),
    .reg_size       (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_valid           (ex_valid),
    .ex_wb_ctrl         (ex_wb_ctrl),
    .ex_mem_ctrl        (ex_mem_ctrl),
    .ex_alu_result      (ex_alu_result),
    .ex_store_data      (ex_store_data),
    .ex_dest_reg        (ex_dest_reg),
    .mem_stall          (mem_stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack),
    .wb_control_signals (wb_control_signals),
    .ReadData           (ReadData),
    .AluResult          (AluResult),
    .destination_reg    (destination_reg),
    .mem_fault          (mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] mc,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst);
    ex_valid      = v;
    ex_wb_ctrl    = wb;
    ex_mem_ctrl   = mc;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_dest_reg   = dst;
  endtask

  task automatic post_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    #3;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wb", wb_control_signals, 2'b00);
    chk("rst_rd", ReadData, 32'h0);
    chk("rst_alu", AluResult, 32'h0);
    chk("rst_dest", destination_reg, 5'd0);
    chk("rst_fault", mem_fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op passes straight through in one cycle
    @(negedge clk);
    drive(1'b1, 2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd5);
    #1;
    chk("alu_stall", mem_stall, 1'b0);
    chk("alu_req", dmem_req, 1'b0);
    post_edge();
    chk("alu_wb", wb_control_signals, 2'b10);
    chk("alu_res", AluResult, 32'h0000_1234);
    chk("alu_dest", destination_reg, 5'd5);
    chk("alu_rd", ReadData, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    post_edge();
    chk("bubble_wb", wb_control_signals, 2'b00);
    chk("bubble_alu", AluResult, 32'h0);

    // Load at 0x100, ack on the third BUSY cycle
    rises_before = req_rises;
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b10, 32'h0000_0100, 32'h0, 5'd7);
    #1;
    chk("ld_stall_idle", mem_stall, 1'b1);
    chk("ld_req_idle", dmem_req, 1'b0);
    post_edge();
    chk("ld_req_busy", dmem_req, 1'b1);
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_addr", dmem_addr, 32'h0000_0100);
    chk("ld_wb_bubble", wb_control_signals, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("ld_stall_wait", mem_stall, 1'b1);
      chk("ld_addr_wait", dmem_addr, 32'h0000_0100);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_ack", mem_stall, 1'b0);
    post_edge();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("ld_rd", ReadData, 32'hDEAD_BEEF);
    chk("ld_wb", wb_control_signals, 2'b11);
    chk("ld_dest", destination_reg, 5'd7);
    chk("ld_alu", AluResult, 32'h0000_0100);
    chk("ld_req_done", dmem_req, 1'b0);
    chk("ld_req_episodes", req_rises - rises_before, 1);

    // Store at 0x104 with immediate ack; rdata on the bus must be ignored
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b01, 32'h0000_0104, 32'hA5A5_A5A5, 5'd9);
    #1;
    chk("st_stall_idle", mem_stall, 1'b1);
    post_edge();
    chk("st_req", dmem_req, 1'b1);
    chk("st_we", dmem_we, 1'b1);
    chk("st_addr", dmem_addr, 32'h0000_0104);
    chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("st_stall_ack", mem_stall, 1'b0);
    chk("st_wdata_ack", dmem_wdata, 32'hA5A5_A5A5);
    post_edge();
    dmem_ack = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("st_wb", wb_control_signals, 2'b00);
    chk("st_rd", ReadData, 32'h0);
    chk("st_alu", AluResult, 32'h0000_0104);
    chk("st_dest", destination_reg, 5'd9);
    chk("st_req_done", dmem_req, 1'b0);
    chk("st_we_done", dmem_we, 1'b0);

    // Misaligned load faults without a request
    rises_before = req_rises;
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b10, 32'h0000_0102, 32'h0, 5'd3);
    #1;
    chk("mis_stall", mem_stall, 1'b0);
    post_edge();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("mis_fault", mem_fault, 1'b1);
    chk("mis_wb", wb_control_signals, 2'b00);
    chk("mis_dest", destination_reg, 5'd0);
    post_edge();
    chk("mis_fault_clr", mem_fault, 1'b0);
    chk("mis_no_req", req_rises - rises_before, 0);

    // Stray ack while idle has no effect
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    post_edge();
    dmem_ack = 1'b0;
    chk("idle_ack_req", dmem_req, 1'b0);
    chk("idle_ack_rd", ReadData, 32'h0);

    // Reset during BUSY, then a late ack
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b10, 32'h0000_0200, 32'h0, 5'd4);
    post_edge();
    chk("rb_req_busy", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_async", dmem_req, 1'b0);
    chk("rb_addr_async", dmem_addr, 32'h0);
    chk("rb_wb_async", wb_control_signals, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    post_edge();
    dmem_ack = 1'b0;
    chk("rb_late_req", dmem_req, 1'b0);
    chk("rb_late_wb", wb_control_signals, 2'b00);
    chk("rb_late_rd", ReadData, 32'h0);
    post_edge();
    chk("rb_idle_req", dmem_req, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // No ack: abort at the end of the eighth BUSY cycle
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b10, 32'h0000_0300, 32'h0, 5'd6);
    post_edge();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("to_stall_wait", mem_stall, 1'b1);
    end
    @(negedge clk);
    #1;
    chk("to_stall_last", mem_stall, 1'b0);
    chk("to_req_last", dmem_req, 1'b1);
    post_edge();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("to_fault", mem_fault, 1'b1);
    chk("to_req_drop", dmem_req, 1'b0);
    chk("to_wb", wb_control_signals, 2'b00);
    post_edge();
    chk("to_fault_clr", mem_fault, 1'b0);

    // Ack on the eighth BUSY cycle completes normally
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b10, 32'h0000_0400, 32'h0, 5'd8);
    post_edge();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000_0055;
    #1;
    chk("ta_stall", mem_stall, 1'b0);
    post_edge();
    dmem_ack = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("ta_fault", mem_fault, 1'b0);
    chk("ta_rd", ReadData, 32'h0000_0055);
    chk("ta_wb", wb_control_signals, 2'b11);
    chk("ta_req", dmem_req, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
